// File: rtl/if_stage_if.sv
// Fetch-stage bundle: ROM address/data, hazard and redirect inputs, IF/ID outputs.
// master = fetch stage side, slave = pipeline/ROM side.
interface if_stage_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus1;
  logic        halted;
  logic [15:0] fetch_count;

  modport master (
    output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, halted, fetch_count,
    input  imem_data, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, halted, fetch_count,
    output imem_data, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_stage.sv
// IITB-RISC instruction fetch: PC, combinational ROM address, IF/ID register,
// stall/redirect handling and a RUN/HALTED FSM that stops on the halt word.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);
  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic [15:0] ipc1_q, ipc1_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= 16'h0000;
      ipc_q   <= 16'h0000;
      ipc1_q  <= 16'h0000;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc1_q  <= ipc1_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect is resolved by an older instruction, so it beats stall and halt;
  // a halt word seen under a taken branch is speculative and gets cancelled here.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc1_d  = ipc1_q;
    cnt_d   = cnt_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      vld_d   = 1'b0;
      state_d = S_RUN;
    end else if (bus.stall) begin
      // everything holds
    end else if (state_q == S_HALTED) begin
      vld_d = 1'b0;
    end else if (bus.imem_data == HALT_WORD) begin
      state_d = S_HALTED;
      vld_d   = 1'b0;
    end else begin
      instr_d = bus.imem_data;
      ipc_d   = pc_q;
      ipc1_d  = pc_q + 16'd1;
      vld_d   = 1'b1;
      pc_d    = pc_q + 16'd1;
      cnt_d   = cnt_q + 16'd1;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_valid    = vld_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc       = ipc_q;
  assign bus.ifid_pc_plus1 = ipc1_q;
  assign bus.halted        = (state_q == S_HALTED);
  assign bus.fetch_count   = cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table for the fetch/redirect/stall/halt/wrap
// scenarios, async reset while halted, then random traffic against a fetch model.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  if_stage_if bus();
  if_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] rom [0:65535];
  assign bus.imem_data = rom[bus.imem_addr];

  typedef struct {
    logic        st;
    logic        rv;
    logic [15:0] rpc;
    logic [15:0] pc;
    logic        vld;
    logic [15:0] ipc;
    logic [15:0] cnt;
    logic        h;
  } vec_t;

  vec_t tbl [23];

  // fetch model state
  logic [15:0] m_pc, m_instr, m_ipc, m_ipc1, m_cnt;
  logic        m_vld, m_halt;

  function automatic vec_t mk(logic st, logic rv, logic [15:0] rpc, logic [15:0] pc,
                              logic vld, logic [15:0] ipc, logic [15:0] cnt, logic h);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.pc = pc;
    v.vld = vld; v.ipc = ipc; v.cnt = cnt; v.h = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_ipc1 = 16'h0000;
    m_cnt = 16'h0000; m_vld = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [15:0] rpc);
    if (rv) begin
      m_pc = rpc; m_vld = 1'b0; m_halt = 1'b0;
    end else if (st) begin
    end else if (m_halt) begin
      m_vld = 1'b0;
    end else if (rom[m_pc] == 16'hFFFF) begin
      m_halt = 1'b1; m_vld = 1'b0;
    end else begin
      m_instr = rom[m_pc]; m_ipc = m_pc; m_ipc1 = m_pc + 16'd1;
      m_vld = 1'b1; m_pc = m_pc + 16'd1; m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".addr"},  bus.imem_addr, m_pc);
    chk({tag, ".vld"},   {15'd0, bus.ifid_valid}, {15'd0, m_vld});
    chk({tag, ".instr"}, bus.ifid_instr, m_instr);
    chk({tag, ".ipc"},   bus.ifid_pc, m_ipc);
    chk({tag, ".ipc1"},  bus.ifid_pc_plus1, m_ipc1);
    chk({tag, ".cnt"},   bus.fetch_count, m_cnt);
    chk({tag, ".halt"},  {15'd0, bus.halted}, {15'd0, m_halt});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = {4'hA, 12'(i)} ^ 16'h0350;
    rom[16'h0031] = 16'hFFFF;
    for (int i = 0; i < 256; i++) if (i % 37 == 36) rom[i] = 16'hFFFF;

    //            st    rv    rpc       pc        vld   ipc       cnt     h
    tbl[0]  = mk(1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 16'h0000, 16'd1,  1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h0001, 16'd2,  1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 16'h0002, 16'd3,  1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 16'h0041, 16'h0041, 1'b0, 16'h0002, 16'd3,  1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 16'h0000, 16'h0042, 1'b1, 16'h0041, 16'd4,  1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 16'h0000, 16'h0043, 1'b1, 16'h0042, 16'd5,  1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 16'h0000, 16'h0043, 1'b1, 16'h0042, 16'd5,  1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 16'h0000, 16'h0043, 1'b1, 16'h0042, 16'd5,  1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 16'h0000, 16'h0043, 1'b1, 16'h0042, 16'd5,  1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 16'h0000, 16'h0044, 1'b1, 16'h0043, 16'd6,  1'b0);
    tbl[10] = mk(1'b1, 1'b1, 16'h002E, 16'h002E, 1'b0, 16'h0043, 16'd6,  1'b0);
    tbl[11] = mk(1'b0, 1'b0, 16'h0000, 16'h002F, 1'b1, 16'h002E, 16'd7,  1'b0);
    tbl[12] = mk(1'b0, 1'b0, 16'h0000, 16'h0030, 1'b1, 16'h002F, 16'd8,  1'b0);
    tbl[13] = mk(1'b0, 1'b0, 16'h0000, 16'h0031, 1'b1, 16'h0030, 16'd9,  1'b0);
    tbl[14] = mk(1'b0, 1'b0, 16'h0000, 16'h0031, 1'b0, 16'h0030, 16'd9,  1'b1);
    tbl[15] = mk(1'b0, 1'b0, 16'h0000, 16'h0031, 1'b0, 16'h0030, 16'd9,  1'b1);
    tbl[16] = mk(1'b1, 1'b0, 16'h0000, 16'h0031, 1'b0, 16'h0030, 16'd9,  1'b1);
    tbl[17] = mk(1'b0, 1'b1, 16'h001F, 16'h001F, 1'b0, 16'h0030, 16'd9,  1'b0);
    tbl[18] = mk(1'b0, 1'b0, 16'h0000, 16'h0020, 1'b1, 16'h001F, 16'd10, 1'b0);
    tbl[19] = mk(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h001F, 16'd10, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'd11, 1'b0);
    tbl[21] = mk(1'b0, 1'b1, 16'h0031, 16'h0031, 1'b0, 16'hFFFF, 16'd11, 1'b0);
    tbl[22] = mk(1'b0, 1'b0, 16'h0000, 16'h0031, 1'b0, 16'hFFFF, 16'd11, 1'b1);

    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0000;

    #3;
    chk("rst.addr",  bus.imem_addr, 16'h0000);
    chk("rst.vld",   {15'd0, bus.ifid_valid}, 16'd0);
    chk("rst.instr", bus.ifid_instr, 16'h0000);
    chk("rst.ipc",   bus.ifid_pc, 16'h0000);
    chk("rst.ipc1",  bus.ifid_pc_plus1, 16'h0000);
    chk("rst.cnt",   bus.fetch_count, 16'h0000);
    chk("rst.halt",  {15'd0, bus.halted}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      bus.stall = tbl[i].st; bus.redirect_valid = tbl[i].rv; bus.redirect_pc = tbl[i].rpc;
      tick();
      chk($sformatf("v%0d.pc", i),    bus.imem_addr, tbl[i].pc);
      chk($sformatf("v%0d.vld", i),   {15'd0, bus.ifid_valid}, {15'd0, tbl[i].vld});
      chk($sformatf("v%0d.ipc", i),   bus.ifid_pc, tbl[i].ipc);
      chk($sformatf("v%0d.ipc1", i),  bus.ifid_pc_plus1, tbl[i].ipc + 16'd1);
      chk($sformatf("v%0d.instr", i), bus.ifid_instr, rom[tbl[i].ipc]);
      chk($sformatf("v%0d.cnt", i),   bus.fetch_count, tbl[i].cnt);
      chk($sformatf("v%0d.halt", i),  {15'd0, bus.halted}, {15'd0, tbl[i].h});
    end
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;

    // async reset while halted, mid-cycle
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_model("arst");
    @(negedge clk);
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 16'h0000);
    tick();
    chk_model("restart");

    for (int c = 0; c < 1500; c++) begin
      logic        st, rv;
      logic [15:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'($urandom_range(0, 255));
      bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
      model_step(st, rv, rpc);
      tick();
      chk_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
